pieo_cmd_frontend: RTL and testbench

- Command front-end directly upstream of the PIEO ordered-list core.
- Accepts enqueue requests (id, rank, send_time) and dequeue requests (current time) on independent valid/ready channels, and arbitrates between them round-robin.
- Issues one command at a time to the core with a start/done handshake and returns dequeue results on a valid/ready response channel.
- Tracks list occupancy so enqueues to a full list are back-pressured and dequeues from an empty list never reach the core.

---
 rtl/pieo_cmd_frontend.sv | 132 +++++++++++++
 tb/tb_pieo_cmd_frontend.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pieo_cmd_frontend.sv
// Command front-end for the PIEO ordered-list core. It arbitrates enqueue and
// dequeue requests round-robin, drives one core command at a time, and returns dequeue results.
module pieo_cmd_frontend #(
  parameter int LIST_SIZE = 16,
  parameter int ID_LOG    = 4,
  parameter int RANK_LOG  = 4,
  parameter int TIME_LOG  = 16,
  parameter int ELEM_W    = ID_LOG + RANK_LOG + TIME_LOG
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enq_valid,
  output logic                enq_ready,
  input  logic [ELEM_W-1:0]   enq_elem,
  input  logic                deq_valid,
  output logic                deq_ready,
  input  logic [TIME_LOG-1:0] deq_curr_time,
  input  logic                pieo_ready,
  output logic                pieo_start,
  output logic                pieo_op,
  output logic [ELEM_W-1:0]   pieo_elem,
  output logic [TIME_LOG-1:0] pieo_curr_time,
  input  logic                pieo_done,
  input  logic                pieo_deq_found,
  input  logic [ELEM_W-1:0]   pieo_deq_elem,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_found,
  output logic [ELEM_W-1:0]   res_elem,
  output logic [ID_LOG:0]     occupancy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [ID_LOG:0] FULL = (ID_LOG+1)'(LIST_SIZE);

  state_t              state_q, state_d;
  logic [ID_LOG:0]     occ_q;
  logic                rr_last;
  logic                cmd_op;
  logic [ELEM_W-1:0]   cmd_elem;
  logic [TIME_LOG-1:0] cmd_time;
  logic                found_q;
  logic [ELEM_W-1:0]   relem_q;
  logic                not_full, enq_elig, take_enq, take_deq;

  assign not_full       = occ_q < FULL;
  assign occupancy      = occ_q;
  assign pieo_op        = cmd_op;
  assign pieo_elem      = cmd_elem;
  assign pieo_curr_time = cmd_time;
  assign res_found      = found_q;
  assign res_elem       = relem_q;

  always_comb begin
    state_d    = state_q;
    enq_ready  = 1'b0;
    deq_ready  = 1'b0;
    pieo_start = 1'b0;
    res_valid  = 1'b0;
    enq_elig   = 1'b0;
    take_enq   = 1'b0;
    take_deq   = 1'b0;
    case (state_q)
      IDLE: begin
        enq_elig = enq_valid & not_full;
        // rr_last holds the last granted op (1 = dequeue); a tie goes to the other one
        if (enq_elig && deq_valid) begin
          take_enq = rr_last;
          take_deq = ~rr_last;
        end else begin
          take_enq = enq_elig;
          take_deq = deq_valid;
        end
        enq_ready = not_full & ~take_deq;
        deq_ready = ~take_enq;
        if (take_enq)
          state_d = ISSUE;
        else if (take_deq)
          state_d = (occ_q == '0) ? RESP : ISSUE;
      end
      ISSUE: begin
        pieo_start = pieo_ready;
        if (pieo_ready) state_d = WAIT;
      end
      WAIT: begin
        if (pieo_done) state_d = cmd_op ? RESP : IDLE;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      occ_q    <= '0;
      rr_last  <= 1'b1;
      cmd_op   <= 1'b0;
      cmd_elem <= '0;
      cmd_time <= '0;
      found_q  <= 1'b0;
      relem_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take_enq || take_deq) begin
        rr_last  <= take_deq;
        cmd_op   <= take_deq;
        cmd_elem <= enq_elem;
        cmd_time <= deq_curr_time;
      end
      // Empty-list dequeue short-circuits straight to a not-found response
      if (take_deq && occ_q == '0) begin
        found_q <= 1'b0;
        relem_q <= '0;
      end
      if (state_q == WAIT && pieo_done) begin
        if (!cmd_op) begin
          occ_q <= occ_q + 1'b1;
        end else begin
          found_q <= pieo_deq_found;
          relem_q <= pieo_deq_found ? pieo_deq_elem : '0;
          if (pieo_deq_found && occ_q != '0) occ_q <= occ_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pieo_cmd_frontend.sv
// Directed bench for pieo_cmd_frontend with a small auto-responding core model.
module tb_pieo_cmd_frontend;
  localparam int ELEM_W = 24;

  logic clk = 0, rst = 1;
  logic enq_valid = 0, deq_valid = 0, pieo_ready = 1, pieo_done = 0;
  logic pieo_deq_found = 0, res_ready = 0;
  logic [ELEM_W-1:0] enq_elem = '0, pieo_deq_elem = '0;
  logic [15:0] deq_curr_time = '0;
  logic enq_ready, deq_ready, pieo_start, pieo_op, res_valid, res_found;
  logic [ELEM_W-1:0] pieo_elem, res_elem;
  logic [15:0] pieo_curr_time;
  logic [4:0] occupancy;

  int checks = 0, errors = 0, start_cnt = 0;
  logic core_found = 0;
  logic [ELEM_W-1:0] core_elem = '0;

  pieo_cmd_frontend dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_elem(enq_elem),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_curr_time(deq_curr_time),
    .pieo_ready(pieo_ready), .pieo_start(pieo_start), .pieo_op(pieo_op),
    .pieo_elem(pieo_elem), .pieo_curr_time(pieo_curr_time),
    .pieo_done(pieo_done), .pieo_deq_found(pieo_deq_found), .pieo_deq_elem(pieo_deq_elem),
    .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
    .res_elem(res_elem), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pieo_start) start_cnt <= start_cnt + 1;

  // Core model: pulse done two cycles after each observed start
  initial begin
    forever begin
      @(posedge clk);
      if (pieo_start) begin
        @(posedge clk);
        #1 pieo_done = 1; pieo_deq_found = core_found; pieo_deq_elem = core_elem;
        @(posedge clk);
        #1 pieo_done = 0; pieo_deq_found = 0; pieo_deq_elem = '0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Wait until back in IDLE (deq_ready high with no enqueue offered)
  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (deq_ready && !enq_valid) begin ok = 1; break; end
      step();
    end
  endtask

  task automatic wait_res(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid) begin ok = 1; break; end
      step();
    end
  endtask

  task automatic do_enq(input logic [ELEM_W-1:0] e, output bit ok);
    bit acc = 0;
    enq_valid = 1; enq_elem = e;
    for (int i = 0; i < 40; i++) begin
      if (enq_ready) begin step(); acc = 1; break; end
      step();
    end
    enq_valid = 0;
    wait_idle(ok);
    ok = ok & acc;
  endtask

  task automatic test_reset();
    rst = 1; repeat (3) step(); rst = 0;
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (pieo_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", pieo_start); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); end
    checks++; if (deq_ready !== 1'b1) begin errors++; $display("FAIL reset_deq_ready: got %b expected 1", deq_ready); end
  endtask

  task automatic test_deq_empty();
    int s0 = start_cnt;
    deq_valid = 1; deq_curr_time = 16'd50;
    checks++; if (deq_ready !== 1'b1) begin errors++; $display("FAIL empty_deq_ready: got %b expected 1", deq_ready); end
    step(); deq_valid = 0;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL empty_res_valid: got %b expected 1", res_valid); end
    checks++; if (res_found !== 1'b0) begin errors++; $display("FAIL empty_res_found: got %b expected 0", res_found); end
    checks++; if (res_elem !== '0) begin errors++; $display("FAIL empty_res_elem: got %0h expected 0", res_elem); end
    res_ready = 1; step(); res_ready = 0; step();
    checks++; if (start_cnt !== s0) begin errors++; $display("FAIL empty_no_start: got %0d expected %0d", start_cnt, s0); end
  endtask

  task automatic test_enq_basic();
    bit ok, seen_res = 0;
    enq_valid = 1; enq_elem = {4'd3, 4'd5, 16'd100};
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL enq_ready: got %b expected 1", enq_ready); end
    step(); enq_valid = 0;
    checks++; if (pieo_start !== 1'b1) begin errors++; $display("FAIL enq_start: got %b expected 1", pieo_start); end
    checks++; if (pieo_op !== 1'b0) begin errors++; $display("FAIL enq_op: got %b expected 0", pieo_op); end
    checks++; if (pieo_elem !== 24'h35_0064) begin errors++; $display("FAIL enq_elem: got %0h expected 350064", pieo_elem); end
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid) seen_res = 1;
      if (deq_ready) begin ok = 1; break; end
      step();
    end
    checks++; if (!ok || seen_res) begin errors++; $display("FAIL enq_done: idle %b res_seen %b expected 1/0", ok, seen_res); end
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL enq_occ: got %0d expected 1", occupancy); end
  endtask

  task automatic test_full();
    bit ok, all_ok = 1;
    for (int i = 0; i < 15; i++) begin
      do_enq(ELEM_W'(i), ok); all_ok &= ok;
    end
    checks++; if (!all_ok) begin errors++; $display("FAIL full_fill: enqueue timed out"); end
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL full_occ: got %0d expected 16", occupancy); end
    enq_valid = 1; #1;
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_enq_ready: got %b expected 0", enq_ready); end
    enq_valid = 0;
    core_found = 1; core_elem = {4'd7, 4'd2, 16'd10};
    deq_valid = 1; deq_curr_time = 16'd20; step(); deq_valid = 0;
    wait_res(ok);
    checks++; if (!ok || res_found !== 1'b1) begin errors++; $display("FAIL full_res_found: got %b expected 1", res_found); end
    checks++; if (res_elem !== 24'h72_000a) begin errors++; $display("FAIL full_res_elem: got %0h expected 72000a", res_elem); end
    checks++; if (occupancy !== 5'd15) begin errors++; $display("FAIL full_occ_after: got %0d expected 15", occupancy); end
    res_ready = 1; step(); res_ready = 0;
    enq_valid = 1; #1;
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL full_enq_ready_after: got %b expected 1", enq_ready); end
    enq_valid = 0; #1;
  endtask

  task automatic test_round_robin();
    logic exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic got [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int n = 0;
    core_found = 1; res_ready = 1;
    enq_valid = 1; deq_valid = 1; enq_elem = 24'h11_0001; #1;
    for (int i = 0; i < 200 && n < 4; i++) begin
      if (enq_valid && enq_ready) begin got[n] = 1'b0; n++; end
      else if (deq_valid && deq_ready) begin got[n] = 1'b1; n++; end
      step();
    end
    enq_valid = 0; deq_valid = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", i, got[i], exp[i]); end
    end
    begin
      bit ok; wait_idle(ok);
    end
    res_ready = 0;
    checks++; if (occupancy !== 5'd15) begin errors++; $display("FAIL rr_occ: got %0d expected 15", occupancy); end
  endtask

  task automatic test_resp_hold();
    bit ok;
    core_found = 0; core_elem = 24'hab_cdef;
    deq_valid = 1; step(); deq_valid = 0;
    wait_res(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_res: res_valid timed out"); end
    enq_valid = 1; deq_valid = 1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (res_valid !== 1'b1 || res_found !== 1'b0 || res_elem !== '0) begin
        errors++; $display("FAIL hold_res_stable%0d: got v%b f%b e%0h expected v1 f0 e0", i, res_valid, res_found, res_elem); end
      checks++; if (enq_ready !== 1'b0 || deq_ready !== 1'b0) begin
        errors++; $display("FAIL hold_no_accept%0d: got %b%b expected 00", i, enq_ready, deq_ready); end
      checks++; if (occupancy !== 5'd15) begin errors++; $display("FAIL hold_occ%0d: got %0d expected 15", i, occupancy); end
      step();
    end
    enq_valid = 0; deq_valid = 0;
    res_ready = 1; step(); res_ready = 0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %b expected 0", res_valid); end
  endtask

  task automatic test_stall_reset();
    pieo_ready = 0;
    enq_valid = 1; enq_elem = 24'h99_0099; step(); enq_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (pieo_start !== 1'b0) begin errors++; $display("FAIL stall_start%0d: got %b expected 0", i, pieo_start); end
      step();
    end
    pieo_ready = 1; #1;
    checks++; if (pieo_start !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", pieo_start); end
    step();
    checks++; if (pieo_elem !== 24'h99_0099) begin errors++; $display("FAIL wait_elem_hold: got %0h expected 990099", pieo_elem); end
    rst = 1; step(); rst = 0;
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL rst_occ: got %0d expected 0", occupancy); end
    checks++; if (res_valid !== 1'b0 || deq_ready !== 1'b1) begin
      errors++; $display("FAIL rst_idle: got rv%b dr%b expected rv0 dr1", res_valid, deq_ready); end
    repeat (4) step();
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL rst_stray_done: got %0d expected 0", occupancy); end
  endtask

  initial begin
    test_reset();
    test_deq_empty();
    test_enq_basic();
    test_full();
    test_round_robin();
    test_resp_hold();
    test_stall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
